fir_sample_source: RTL and testbench

Programmable stimulus sequencer that drives the 8-bit `{sample[5:0], mode[1:0]}` input word of the FIR filter tile. It emits a finite burst of 6-bit samples (impulse, step, ramp, square, LFSR noise, constant), holding each word for a fixed number of cycles so the filter's registered pipeline settles before the next sample. It sits in front of the filter in the on-chip self-test path and in block-level benches as the synthesizable sample writer.

---
 rtl/fir_pkg.sv | 49 ++++
 rtl/fir_sample_source_lfsr8.sv | 20 ++
 rtl/fir_sample_source.sv | 145 ++++++++++++++
 tb/tb_fir_sample_source.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types, widths and helpers for the FIR filter tile and its stimulus source.
package fir_pkg;

    localparam int SAMPLE_W = 6;
    localparam int MODE_W   = 2;

    // Right-shift Galois feedback mask for x^8+x^6+x^5+x^4+1
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        MODE_BYPASS,
        MODE_MAVG,
        MODE_LPF,
        MODE_HPF
    } fir_mode_e;

    typedef enum logic [2:0] {
        PAT_IMPULSE,
        PAT_STEP,
        PAT_RAMP,
        PAT_SQUARE,
        PAT_NOISE,
        PAT_CONST,
        PAT_ZERO6,
        PAT_ZERO7
    } pattern_e;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {1'b0, s[7:1]} ^ (s[0] ? LFSR_TAPS : 8'h00);
    endfunction

    function automatic logic [SAMPLE_W-1:0] sample_value(
        input pattern_e              p,
        input logic [7:0]            k,
        input logic [SAMPLE_W-1:0]   a,
        input logic [7:0]            lfsr
    );
        case (p)
            PAT_IMPULSE: return (k == 8'd0) ? a : '0;
            PAT_STEP:    return (k == 8'd0) ? '0 : a;
            PAT_RAMP:    return k[SAMPLE_W-1:0];
            PAT_SQUARE:  return k[2] ? '0 : a;
            PAT_NOISE:   return lfsr[SAMPLE_W-1:0];
            PAT_CONST:   return a;
            default:     return '0;
        endcase
    endfunction

endpackage

// File: rtl/fir_sample_source_lfsr8.sv
// 8-bit Galois noise LFSR: synchronous load of the seed, one step per advance.
module fir_lfsr8
    import fir_pkg::*;
#(
    parameter logic [7:0] SEED = 8'h01
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic       advance,
    output logic [7:0] state
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)        state <= SEED;
        else if (load)    state <= SEED;
        else if (advance) state <= lfsr_step(state);
    end

endmodule

// File: rtl/fir_sample_source.sv
// Burst stimulus sequencer driving {sample, mode} into the FIR tile, each word
// held HOLD_CYCLES cycles; all outputs registered from next-state logic.
module fir_sample_source
    import fir_pkg::*;
#(
    parameter int         HOLD_CYCLES = 3,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [2:0] pattern,
    input  logic [1:0] mode,
    input  logic [5:0] amplitude,
    input  logic [7:0] length,
    output logic [7:0] ui_word,
    output logic       sample_valid,
    output logic       busy,
    output logic       done,
    output logic [7:0] sample_idx
);

    localparam int         HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [7:0] SEED_EFF  = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE} state_e;

    state_e            state, state_n;
    logic [HW-1:0]     hold_cnt, hold_n;
    pattern_e          pat_q;
    logic [MODE_W-1:0] mode_q;
    logic [SAMPLE_W-1:0] amp_q;
    logic [7:0]        len_q;

    logic [7:0] word_n, idx_n;
    logic       valid_n, busy_n, done_n;
    logic       latch, lfsr_load, lfsr_adv;
    logic [7:0] lfsr_q, lfsr_nx;

    fir_lfsr8 #(.SEED(SEED_EFF)) u_lfsr (
        .clock   (clock),
        .reset   (reset),
        .load    (lfsr_load),
        .advance (lfsr_adv),
        .state   (lfsr_q)
    );

    // Next word's noise sample is the value the LFSR is about to take
    assign lfsr_nx = lfsr_step(lfsr_q);

    always_comb begin
        state_n   = state;
        hold_n    = hold_cnt;
        idx_n     = sample_idx;
        word_n    = ui_word;
        valid_n   = 1'b0;
        busy_n    = busy;
        done_n    = 1'b0;
        latch     = 1'b0;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;
        case (state)
            S_IDLE: begin
                word_n = {{SAMPLE_W{1'b0}}, mode_q};
                busy_n = 1'b0;
                if (start && !abort) begin
                    latch     = 1'b1;
                    lfsr_load = 1'b1;
                    idx_n     = 8'd0;
                    hold_n    = '0;
                    if (length == 8'd0) begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                        word_n  = {{SAMPLE_W{1'b0}}, mode};
                    end else begin
                        state_n = S_EMIT;
                        busy_n  = 1'b1;
                        valid_n = 1'b1;
                        word_n  = {sample_value(pattern_e'(pattern), 8'd0, amplitude, SEED_EFF), mode};
                    end
                end
            end
            S_EMIT: begin
                if (abort) begin
                    state_n = S_IDLE;
                    busy_n  = 1'b0;
                    word_n  = {{SAMPLE_W{1'b0}}, mode_q};
                end else if (hold_cnt == HOLD_LAST) begin
                    hold_n = '0;
                    if (sample_idx == len_q - 8'd1) begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        word_n  = {{SAMPLE_W{1'b0}}, mode_q};
                    end else begin
                        idx_n    = sample_idx + 8'd1;
                        valid_n  = 1'b1;
                        lfsr_adv = 1'b1;
                        word_n   = {sample_value(pat_q, sample_idx + 8'd1, amp_q, lfsr_nx), mode_q};
                    end
                end else begin
                    hold_n = hold_cnt + HW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
                word_n  = {{SAMPLE_W{1'b0}}, mode_q};
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            hold_cnt     <= '0;
            pat_q        <= PAT_IMPULSE;
            mode_q       <= '0;
            amp_q        <= '0;
            len_q        <= 8'd0;
            ui_word      <= 8'h00;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sample_idx   <= 8'd0;
        end else begin
            state        <= state_n;
            hold_cnt     <= hold_n;
            ui_word      <= word_n;
            sample_valid <= valid_n;
            busy         <= busy_n;
            done         <= done_n;
            sample_idx   <= idx_n;
            if (latch) begin
                pat_q  <= pattern_e'(pattern);
                mode_q <= mode;
                amp_q  <= amplitude;
                len_q  <= length;
            end
        end
    end

endmodule

// File: tb/tb_fir_sample_source.sv
// Bench for fir_sample_source: burst-trace model per instance (H=3 and H=1) checked every cycle.
module tb_fir_sample_source;

    logic       clock = 1'b0;
    logic       reset;
    logic       start_i [2];
    logic       abort_i [2];
    logic [2:0] pat_i   [2];
    logic [1:0] mode_i  [2];
    logic [5:0] amp_i   [2];
    logic [7:0] len_i   [2];
    logic [7:0] word_o  [2];
    logic [7:0] idx_o   [2];
    logic       valid_o [2];
    logic       busy_o  [2];
    logic       done_o  [2];

    always #5 clock = ~clock;

    fir_sample_source #(.HOLD_CYCLES(3), .LFSR_SEED(8'hA5)) dut0 (
        .clock(clock), .reset(reset), .start(start_i[0]), .abort(abort_i[0]),
        .pattern(pat_i[0]), .mode(mode_i[0]), .amplitude(amp_i[0]), .length(len_i[0]),
        .ui_word(word_o[0]), .sample_valid(valid_o[0]), .busy(busy_o[0]),
        .done(done_o[0]), .sample_idx(idx_o[0])
    );

    fir_sample_source #(.HOLD_CYCLES(1), .LFSR_SEED(8'hA5)) dut1 (
        .clock(clock), .reset(reset), .start(start_i[1]), .abort(abort_i[1]),
        .pattern(pat_i[1]), .mode(mode_i[1]), .amplitude(amp_i[1]), .length(len_i[1]),
        .ui_word(word_o[1]), .sample_valid(valid_o[1]), .busy(busy_o[1]),
        .done(done_o[1]), .sample_idx(idx_o[1])
    );

    typedef struct {
        logic [7:0] word;
        logic       valid;
        logic       busy;
        logic       done;
        logic [7:0] idx;
    } exp_t;

    exp_t       q0[$];
    exp_t       q1[$];
    logic [1:0] mode_m [2];
    int         total = 0;
    int         bad   = 0;
    int         ncyc  = 0;
    logic [7:0] hw [2][1024];
    logic [7:0] hi [2][1024];
    logic       hv [2][1024];
    logic       hd [2][1024];

    function automatic logic [7:0] galois(input logic [7:0] s);
        return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
    endfunction

    function automatic logic [5:0] model_sample(input int p, input int k, input logic [5:0] a,
                                                input logic [7:0] n);
        case (p)
            0:       return (k == 0) ? a : 6'd0;
            1:       return (k == 0) ? 6'd0 : a;
            2:       return 6'(k % 64);
            3:       return (((k / 4) % 2) == 0) ? a : 6'd0;
            4:       return n[5:0];
            5:       return a;
            default: return 6'd0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, wanted %0h", nm, act, exp);
        end
    endtask

    // One clock: compare outputs of the previous edge at the negedge, then advance past the next edge.
    task automatic tick();
        @(negedge clock);
        for (int id = 0; id < 2; id++) begin
            exp_t e;
            if (ncyc < 1024) begin
                hw[id][ncyc] = word_o[id];
                hi[id][ncyc] = idx_o[id];
                hv[id][ncyc] = valid_o[id];
                hd[id][ncyc] = done_o[id];
            end
            if (!reset) begin
                e = '{word: {6'd0, mode_m[id]}, valid: 1'b0, busy: 1'b0, done: 1'b0, idx: 8'd0};
                if (id == 0 && q0.size() > 0) e = q0.pop_front();
                if (id == 1 && q1.size() > 0) e = q1.pop_front();
                chk($sformatf("dut%0d cyc%0d {word,valid,busy,done}", id, ncyc),
                    {word_o[id], valid_o[id], busy_o[id], done_o[id]},
                    {e.word, e.valid, e.busy, e.done});
                if (e.busy)
                    chk($sformatf("dut%0d cyc%0d sample_idx", id, ncyc), idx_o[id], e.idx);
            end
        end
        ncyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic flush(input int id);
        if (id == 0) q0.delete();
        else q1.delete();
    endtask

    task automatic drive(input int id, input int p, input logic [1:0] m, input logic [5:0] a,
                         input logic [7:0] len);
        pat_i[id]  = 3'(p);
        mode_i[id] = m;
        amp_i[id]  = a;
        len_i[id]  = len;
    endtask

    // Start a burst and queue the expected per-cycle trace; base = history index of the start edge.
    task automatic do_start(input int id, input int p, input logic [1:0] m, input logic [5:0] a,
                            input logic [7:0] len, output int base);
        exp_t       e;
        logic [7:0] n;
        int         h;
        drive(id, p, m, a, len);
        start_i[id] = 1'b1;
        tick();
        start_i[id] = 1'b0;
        base = ncyc;
        mode_m[id] = m;
        n = 8'hA5;
        h = (id == 0) ? 3 : 1;
        for (int k = 0; k < int'(len); k++) begin
            for (int c = 0; c < h; c++) begin
                e = '{word: {model_sample(p, k, a, n), m}, valid: (c == 0), busy: 1'b1,
                      done: 1'b0, idx: 8'(k)};
                if (id == 0) q0.push_back(e);
                else q1.push_back(e);
            end
            n = galois(n);
        end
        e = '{word: {6'd0, m}, valid: 1'b0, busy: 1'b0, done: 1'b1, idx: 8'd0};
        if (id == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    initial begin
        int b, b2, cnt;
        reset = 1'b1;
        for (int id = 0; id < 2; id++) begin
            start_i[id] = 1'b0;
            abort_i[id] = 1'b0;
            mode_m[id]  = 2'd0;
            drive(id, 0, 2'd0, 6'd0, 8'd0);
        end
        #2;
        for (int id = 0; id < 2; id++)
            chk($sformatf("reset dut%0d outputs", id),
                {word_o[id], valid_o[id], busy_o[id], done_o[id], idx_o[id]}, 19'd0);
        ticks(2);
        reset = 1'b0;
        ticks(2);

        // Impulse, A=63, mode 01, length 4, H=3
        do_start(0, 0, 2'd1, 6'd63, 8'd4, b);
        ticks(16);
        chk("impulse word c0", hw[0][b], 8'hFD);
        chk("impulse word c2", hw[0][b+2], 8'hFD);
        chk("impulse word c3", hw[0][b+3], 8'h01);
        chk("impulse word c11", hw[0][b+11], 8'h01);
        chk("impulse done c11", hd[0][b+11], 1'b0);
        chk("impulse done c12", hd[0][b+12], 1'b1);
        chk("impulse valid c9", hv[0][b+9], 1'b1);
        cnt = 0;
        for (int i = 0; i <= 12; i++) cnt += int'(hv[0][b+i]);
        chk("impulse valid count", cnt, 4);

        // Ramp, mode 00, length 70, H=1 (wrap at 64)
        do_start(1, 2, 2'd0, 6'd0, 8'd70, b);
        ticks(75);
        chk("ramp word k63", hw[1][b+63], 8'hFC);
        chk("ramp word k64", hw[1][b+64], 8'h00);
        chk("ramp idx last", hi[1][b+69], 8'd69);
        chk("ramp done", hd[1][b+70], 1'b1);
        cnt = 0;
        for (int i = 0; i <= 72; i++) cnt += int'(hv[1][b+i]);
        chk("ramp valid count", cnt, 70);

        // Zero-length burst
        do_start(0, 5, 2'd2, 6'd5, 8'd0, b);
        ticks(4);
        chk("len0 done next cycle", hd[0][b], 1'b1);
        chk("len0 word", hw[0][b], 8'h02);
        chk("len0 done one cycle", hd[0][b+1], 1'b0);
        cnt = 0;
        for (int i = 0; i <= 3; i++) cnt += int'(hv[0][b+i]);
        chk("len0 valid count", cnt, 0);

        // Noise twice with the same seed: samples 0x25, 0x2A, 0x35
        do_start(0, 4, 2'd0, 6'd0, 8'd3, b);
        ticks(12);
        do_start(0, 4, 2'd0, 6'd0, 8'd3, b2);
        ticks(12);
        chk("noise run1 k0", hw[0][b], 8'h94);
        chk("noise run1 k1", hw[0][b+3], 8'hA8);
        chk("noise run1 k2", hw[0][b+6], 8'hD4);
        chk("noise run2 k0", hw[0][b2], 8'h94);
        chk("noise run2 k1", hw[0][b2+3], 8'hA8);
        chk("noise run2 k2", hw[0][b2+6], 8'hD4);

        // Step A=32 mode 11, ignored start mid-burst, abort during word 2
        do_start(0, 1, 2'd3, 6'd32, 8'd10, b);
        ticks(3);
        drive(0, 5, 2'd0, 6'd7, 8'd1);
        start_i[0] = 1'b1;
        tick();
        start_i[0] = 1'b0;
        ticks(2);
        abort_i[0] = 1'b1;
        tick();
        abort_i[0] = 1'b0;
        flush(0);
        chk("abort word", word_o[0], 8'h03);
        chk("abort busy", busy_o[0], 1'b0);
        ticks(12);
        chk("step word k0", hw[0][b], 8'h03);
        chk("step word k1", hw[0][b+3], 8'h83);
        chk("step word k2", hw[0][b+6], 8'h83);
        cnt = 0;
        for (int i = 7; i <= 18; i++) cnt += int'(hd[0][b+i]);
        chk("abort no done", cnt, 0);

        // Reset between edges in the middle of a burst
        do_start(0, 2, 2'd1, 6'd0, 8'd20, b);
        ticks(4);
        chk("ramp pre-reset k1", hw[0][b+3], 8'h05);
        #2;
        reset = 1'b1;
        #1;
        chk("midburst reset outputs",
            {word_o[0], valid_o[0], busy_o[0], done_o[0], idx_o[0]}, 19'd0);
        flush(0);
        flush(1);
        mode_m[0] = 2'd0;
        mode_m[1] = 2'd0;
        tick();
        reset = 1'b0;
        tick();
        do_start(0, 0, 2'd2, 6'd10, 8'd2, b);
        ticks(8);
        chk("post-reset word0", hw[0][b], 8'h2A);
        chk("post-reset idx0", hi[0][b], 8'd0);
        chk("post-reset valid0", hv[0][b], 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
